// File: rtl/pr_read_arbiter.sv
// pr_read_arbiter: round-robin AXI AR arbiter for the V/E fetchers with per-requester credits and RID-based R routing
module pr_read_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W = 16,
  parameter int MAX_OUT = 8,
  parameter int CNT_W = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_req_valid,
  output logic              v_req_ready,
  input  logic [ADDR_W-1:0] v_req_addr,
  input  logic [7:0]        v_req_len,
  input  logic              e_req_valid,
  output logic              e_req_ready,
  input  logic [ADDR_W-1:0] e_req_addr,
  input  logic [7:0]        e_req_len,
  output logic              v_rsp_valid,
  input  logic              v_rsp_ready,
  output logic [DATA_W-1:0] v_rsp_data,
  output logic              v_rsp_last,
  output logic              e_rsp_valid,
  input  logic              e_rsp_ready,
  output logic [DATA_W-1:0] e_rsp_data,
  output logic              e_rsp_last,
  output logic [ID_W-1:0]   arid_m,
  output logic [ADDR_W-1:0] araddr_m,
  output logic [7:0]        arlen_m,
  output logic [2:0]        arsize_m,
  output logic              arvalid_m,
  input  logic              arready_m,
  input  logic [ID_W-1:0]   rid_m,
  input  logic [DATA_W-1:0] rdata_m,
  input  logic [1:0]        rresp_m,
  input  logic              rlast_m,
  input  logic              rvalid_m,
  output logic              rready_m,
  output logic [CNT_W-1:0]  v_outstanding,
  output logic [CNT_W-1:0]  e_outstanding,
  output logic              resp_err,
  output logic              bad_id
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic last_grant;
  logic v_elig, e_elig, grant_e, v_acc, e_acc, v_sel, e_sel, r_hs, v_dec, e_dec;
  function automatic logic [CNT_W-1:0] upd(input logic [CNT_W-1:0] c, input logic inc, input logic dec);
    return (inc && !dec) ? c + CNT_W'(1) : (dec && !inc && c != '0) ? c - CNT_W'(1) : c;
  endfunction
  assign v_elig = v_req_valid && v_outstanding < CNT_W'(MAX_OUT);
  assign e_elig = e_req_valid && e_outstanding < CNT_W'(MAX_OUT);
  assign grant_e = e_elig && (!v_elig || !last_grant);
  assign v_req_ready = state == IDLE && v_elig && !grant_e;
  assign e_req_ready = state == IDLE && grant_e;
  assign v_acc = v_req_valid && v_req_ready;
  assign e_acc = e_req_valid && e_req_ready;
  assign arvalid_m = state == ISSUE;
  assign arsize_m = 3'b110;
  assign v_sel = rid_m == ID_W'(0);
  assign e_sel = rid_m == ID_W'(1);
  assign v_rsp_valid = rvalid_m && v_sel;
  assign e_rsp_valid = rvalid_m && e_sel;
  assign v_rsp_data = rdata_m;
  assign e_rsp_data = rdata_m;
  assign v_rsp_last = rlast_m;
  assign e_rsp_last = rlast_m;
  // Unknown IDs are drained so a stray beat never stalls the R channel
  assign rready_m = v_sel ? v_rsp_ready : e_sel ? e_rsp_ready : 1'b1;
  assign r_hs = rvalid_m && rready_m;
  assign v_dec = r_hs && rlast_m && v_sel;
  assign e_dec = r_hs && rlast_m && e_sel;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (v_acc || e_acc) ? ISSUE : IDLE;
    else state_nx = arready_m ? IDLE : ISSUE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      arid_m <= '0;
      araddr_m <= '0;
      arlen_m <= '0;
      v_outstanding <= '0;
      e_outstanding <= '0;
      resp_err <= 1'b0;
      bad_id <= 1'b0;
    end else begin
      state <= state_nx;
      if (v_acc || e_acc) begin
        last_grant <= e_acc;
        arid_m <= ID_W'(e_acc);
        araddr_m <= {(e_acc ? e_req_addr[ADDR_W-1:6] : v_req_addr[ADDR_W-1:6]), 6'b0};
        arlen_m <= e_acc ? e_req_len : v_req_len;
      end
      v_outstanding <= upd(v_outstanding, v_acc, v_dec);
      e_outstanding <= upd(e_outstanding, e_acc, e_dec);
      if (r_hs && rresp_m != 2'b00) resp_err <= 1'b1;
      if (rvalid_m && !v_sel && !e_sel) bad_id <= 1'b1;
    end
  end
endmodule

// File: doc/pr_read_arbiter.md
Name: pr_read_arbiter

Overview:
- Shares the single AXI read master port between the vertex-array fetcher (requester V, ARID 0) and the in-edge fetcher (requester E, ARID 1).
- Arbitrates AR requests round-robin and limits outstanding bursts per requester with credit counters.
- Routes R-channel beats back to the owning requester by RID.
- Sits between the PageRank fetch sequencer and the shell memory interface.

Parameters:
ADDR_W, 64, byte address width
DATA_W, 512, R data width (one 64-byte line per beat)
ID_W, 16, AXI ID width
MAX_OUT, 8, max outstanding bursts per requester (1..255)
CNT_W, $clog2(MAX_OUT+1), outstanding counter width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
v_req_valid  in  1  V read request valid
v_req_ready  out  1  V request accepted this cycle
v_req_addr  in  ADDR_W  V byte address
v_req_len  in  8  V burst length minus 1 (AXI arlen)
e_req_valid / e_req_ready / e_req_addr / e_req_len  same as V, for E
v_rsp_valid  out  1  beat for V
v_rsp_ready  in  1  V can take beat
v_rsp_data  out  DATA_W  beat data
v_rsp_last  out  1  last beat of V burst
e_rsp_valid / e_rsp_ready / e_rsp_data / e_rsp_last  same as V, for E
arid_m  out  ID_W  AR ID
araddr_m  out  ADDR_W  AR address
arlen_m  out  8  AR length
arsize_m  out  3  constant 3'b110
arvalid_m  out  1  AR valid
arready_m  in  1  AR ready
rid_m  in  ID_W  R ID
rdata_m  in  DATA_W  R data
rresp_m  in  2  R response
rlast_m  in  1  R last
rvalid_m  in  1  R valid
rready_m  out  1  R ready
v_outstanding  out  CNT_W  V bursts in flight
e_outstanding  out  CNT_W  E bursts in flight
resp_err  out  1  sticky: any beat with rresp_m != 0
bad_id  out  1  sticky: beat with RID not 0 or 1

Behaviour:
- States: IDLE, ISSUE. Reset: state IDLE; arvalid_m 0; arid_m/araddr_m/arlen_m 0; outstanding counters 0; resp_err and bad_id 0; last_grant = E, so V wins the first tie.
- Eligible requester (IDLE only): valid and outstanding < MAX_OUT. Exactly one eligible: it is granted. Both eligible: grant the one not equal to last_grant.
- x_req_ready is combinational and high only for the granted requester in IDLE. Handshake happens when valid and ready are both high.
- On accept, same edge:
  - latch araddr = addr with bits [5:0] forced to 0, arlen = len, arid = requester index;
  - increment that requester's counter (credit reserved at accept);
  - last_grant <= requester;
  - state <= ISSUE.
- ISSUE: arvalid_m = 1. AR fields stay stable until arready_m. On arready_m: arvalid_m <= 0 next cycle, state <= IDLE.
  - Latency: accept at cycle N puts arvalid_m high at N+1.
  - Peak issue rate is one AR per 2 cycles.
- R routing is combinational, no added latency:
  - rid_m == 0: v_rsp_valid = rvalid_m, rready_m = v_rsp_ready.
  - rid_m == 1: same, using the E signals.
  - Any other RID: rready_m = 1, beat dropped, bad_id <= 1.
  - rsp_data = rdata_m and rsp_last = rlast_m for both requesters.
- rvalid_m & rready_m & rresp_m != 0 sets resp_err. That beat is still forwarded.
- Counter decrement happens on a beat of that ID where rvalid_m & rready_m & rlast_m are all high.
  - Increment and decrement in the same cycle: net unchanged.
  - Decrement at 0 saturates. This covers stale responses after a mid-operation reset.
- Counter at MAX_OUT: that requester is ineligible. The other requester is still served with no blocking.
- Reset in ISSUE: arvalid_m drops the next cycle. Stale R beats are still accepted and routed; any counter decrement saturates at 0.

Test Plan:
- V only: addr 0x1047, len 0 -> araddr_m 0x1040, arid_m 0, arlen_m 0, arsize_m 6; arvalid_m rises 1 cycle after accept; v_outstanding becomes 1, then returns to 0 after a 1-beat R with rlast.
- V and E valid every cycle, arready_m always 1 -> grants alternate V,E,V,E starting with V; 4 ARs in 8 cycles.
- MAX_OUT=2, E valid, no R returns -> e_req_ready stays low after 2 accepts; V still granted; one E rlast beat -> next E accepted.
- R beats with rid 1, len 3, e_rsp_ready toggling 1,0,1 -> rready_m follows e_rsp_ready; 4 beats delivered in order; e_outstanding drops only on the rlast beat.
- rid_m = 5 beat -> rready_m=1, no rsp_valid, bad_id=1; beat with rresp_m=2 on rid 0 -> forwarded and resp_err=1; both flags hold until rst.
- rst asserted while arvalid_m=1 and arready_m=0 -> arvalid_m=0 and counters 0 next cycle; a later stale rid 0 rlast beat leaves v_outstanding at 0.
